useq_mbox_sched: RTL
====================

Name: useq_mbox_sched

Overview:
Mailbox scheduler that shares one host byte channel across N_CORES useq microsequencer cores through their external FIFO ports (write_fifo/read_fifo/fifo_in/fifo_out/fifo_empty/fifo_full).
- Arbitrates host write and read requests.
- Issues single-cycle FIFO strobes to the addressed core.
- Enforces a per-core strobe gap. A strobe stalls that core's CPU for the cycle.
- Returns read data with a fixed latency.

Parameters:
N_CORES, 4, number of attached useq cores (1..16)
CW, 2, core index width; must satisfy 2**CW >= N_CORES
GAP, 2, minimum idle cycles between consecutive strobes to the same core (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wr_valid  in  1  host write request
wr_core  in  CW  target core of write
wr_data  in  8  byte to push
wr_ready  out  1  write handshake accepted this cycle
rd_valid  in  1  host read request
rd_core  in  CW  target core of read
rd_ready  out  1  read handshake accepted this cycle
resp_valid  out  1  one-cycle read response pulse
resp_data  out  8  byte popped (0 if empty/err)
resp_empty  out  1  target FIFO was empty; no pop done
resp_err  out  1  core index >= N_CORES
core_write_fifo  out  N_CORES  per-core write strobe
core_read_fifo  out  N_CORES  per-core read strobe
core_fifo_in  out  8  write data, broadcast to all cores
core_fifo_out  in  8*N_CORES  core k fifo_out at bits [8k+7:8k]
core_fifo_empty  in  N_CORES  per-core empty flag
core_fifo_full  in  N_CORES  per-core full flag

Behaviour:
- Reset: the clock is clk and reset is rst_n, synchronous, active-low. On reset, all outputs are 0, the FSM goes to IDLE, gap counters clear, and last_grant = read. A reset mid-operation drops any in-flight request, and no strobe is asserted in the cycle after reset.
- FSM states: IDLE, WSTB, RSTB, RWAIT, RCAP. Handshakes occur only in IDLE; wr_ready and rd_ready are 0 in all other states.
- Write eligibility: wr_valid && wr_core<N_CORES && !core_fifo_full[wr_core] && gap[wr_core]==0.
- Read eligibility: rd_valid && (rd_core>=N_CORES || core_fifo_empty[rd_core] || gap[rd_core]==0).
- Invalid write index: wr_ready=1 and the byte is discarded. No strobe, FSM stays in IDLE.
- Arbitration in IDLE:
  - If only one request is eligible, grant it.
  - If both are eligible, grant the one opposite last_grant, then update last_grant.
  - At most one handshake per cycle. Readies are combinational from the registered state plus the eligibility terms.
- Write accepted at cycle T:
  - FSM goes to WSTB.
  - At T+1: core_write_fifo[k]=1 for exactly one cycle and core_fifo_in=wr_data (held until the next write).
  - FSM returns to IDLE at T+2.
- Read accepted at T, target empty or invalid: no strobe. At T+1: resp_valid=1, resp_data=0, resp_empty=1 (empty case) or resp_err=1 (invalid case). FSM goes to RCAP then IDLE.
- Read accepted at T, target non-empty:
  - T+1 (RSTB): core_read_fifo[k]=1 for one cycle.
  - T+2 (RWAIT): the core's fifo_out is updated.
  - End of T+2: capture into resp_data.
  - T+3 (RCAP): resp_valid=1, resp_empty=0, resp_err=0. FSM returns to IDLE.
- Response: resp_* are registered and valid only while resp_valid=1. There is no backpressure; resp_data holds its value until the next response.
- Gap counters: loaded with GAP in the cycle the strobe to core k is asserted, then decrement to 0. A counter that is nonzero blocks eligibility for that core only; other cores proceed.
- Full/empty flags are sampled in the handshake cycle only.
- Never assert write and read strobes to the same core in the same cycle (the useq ignores simultaneous strobes).
- A blocked write (target full) must not block reads. Reads are still granted, which lets the host drain.

Test Plan:
- Write 0xA5 to core 2, idle bench: wr_ready at T, core_write_fifo=4'b0100 only at T+1, core_fifo_in=0xA5, FSM back to IDLE at T+2.
- Read core 1 with core_fifo_out[15:8]=0x3C, empty[1]=0: core_read_fifo=4'b0010 at T+1, resp_valid at T+3 with resp_data=0x3C, resp_empty=0.
- Read core 3 with empty[3]=1: no strobe, resp_valid at T+1 with resp_empty=1, resp_data=0x00.
- wr_valid and rd_valid held constantly on core 0, GAP=2, flags permissive: grants alternate write/read, and successive strobes to core 0 are at least 3 cycles apart.
- Write to full core 1 while reading core 0: wr_ready stays 0 and reads complete normally; deassert full[1] and the write is accepted next IDLE cycle.
- N_CORES=3, CW=2, write/read core 3: write accepted with no strobe; read gives resp_err=1, resp_data=0. Separately, assert rst_n=0 during RWAIT: the next cycle has all strobes 0 and resp_valid 0, and the FSM is in IDLE.

Source files
------------

// File: rtl/useq_mbox_sched.sv
`default_nettype none
// ============================================================================
//  Module   : useq_mbox_sched
//  Purpose  : Shares one host byte channel across N_CORES useq cores through
//             their external FIFO ports. Arbitrates host write/read requests,
//             issues single-cycle FIFO strobes, enforces a per-core strobe gap
//             and returns read data with a fixed latency.
//  Revision : 1.0  initial release
// ============================================================================
module useq_mbox_sched #(
  parameter int N_CORES = 4,
  parameter int CW      = 2,
  parameter int GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // host write channel
  input  logic                 wr_valid_i,
  input  logic [CW-1:0]        wr_core_i,
  input  logic [7:0]           wr_data_i,
  output logic                 wr_ready_o,
  // host read channel
  input  logic                 rd_valid_i,
  input  logic [CW-1:0]        rd_core_i,
  output logic                 rd_ready_o,
  output logic                 resp_valid_o,
  output logic [7:0]           resp_data_o,
  output logic                 resp_empty_o,
  output logic                 resp_err_o,
  // core FIFO ports
  output logic [N_CORES-1:0]   core_write_fifo_o,
  output logic [N_CORES-1:0]   core_read_fifo_o,
  output logic [7:0]           core_fifo_in_o,
  input  logic [8*N_CORES-1:0] core_fifo_out_i,
  input  logic [N_CORES-1:0]   core_fifo_empty_i,
  input  logic [N_CORES-1:0]   core_fifo_full_i
);

  localparam logic [3:0]  C_GAP     = 4'(GAP);
  localparam logic [CW:0] C_N_CORES = (CW+1)'(N_CORES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WSTB  = 3'd1,
    S_RSTB  = 3'd2,
    S_RWAIT = 3'd3,
    S_RCAP  = 3'd4
  } state_e;

  state_e               state_q;
  logic                 last_wr_q;     // 1: last grant was a write, 0: a read
  logic [CW-1:0]        sel_q;         // core whose fifo_out is captured
  logic [3:0]           gap_q [N_CORES];
  logic [N_CORES-1:0]   core_write_fifo_q;
  logic [N_CORES-1:0]   core_read_fifo_q;
  logic [7:0]           core_fifo_in_q;
  logic                 resp_valid_q;
  logic [7:0]           resp_data_q;
  logic                 resp_empty_q;
  logic                 resp_err_q;

  logic                 w_idle;
  logic                 w_wr_inv;
  logic                 w_rd_inv;
  logic                 w_wr_full;
  logic                 w_wr_busy;
  logic                 w_rd_empty;
  logic                 w_rd_busy;
  logic                 w_wr_elig;
  logic                 w_rd_elig;
  logic                 w_wr_grant;
  logic                 w_rd_grant;
  logic [N_CORES-1:0]   w_wr_onehot;
  logic [N_CORES-1:0]   w_rd_onehot;
  logic [7:0]           w_cap_data;

  // Select the addressed core's flags/gap and decide the grant for this cycle.
  always_comb begin
    w_idle      = (state_q == S_IDLE) && rst_n;
    w_wr_inv    = {1'b0, wr_core_i} >= C_N_CORES;
    w_rd_inv    = {1'b0, rd_core_i} >= C_N_CORES;
    w_wr_full   = 1'b0;
    w_wr_busy   = 1'b0;
    w_rd_empty  = 1'b0;
    w_rd_busy   = 1'b0;
    w_wr_onehot = '0;
    w_rd_onehot = '0;
    w_cap_data  = 8'h00;
    for (int k = 0; k < N_CORES; k++) begin
      if (wr_core_i == CW'(k)) begin
        w_wr_full      = core_fifo_full_i[k];
        w_wr_busy      = (gap_q[k] != 4'd0);
        w_wr_onehot[k] = 1'b1;
      end
      if (rd_core_i == CW'(k)) begin
        w_rd_empty     = core_fifo_empty_i[k];
        w_rd_busy      = (gap_q[k] != 4'd0);
        w_rd_onehot[k] = 1'b1;
      end
      if (sel_q == CW'(k)) begin
        w_cap_data = core_fifo_out_i[8*k +: 8];
      end
    end
    // An out-of-range write is accepted and dropped, so it counts as eligible.
    w_wr_elig  = w_idle && wr_valid_i && (w_wr_inv || (!w_wr_full && !w_wr_busy));
    // Empty/invalid reads never strobe, so the gap does not hold them back.
    w_rd_elig  = w_idle && rd_valid_i && (w_rd_inv || w_rd_empty || !w_rd_busy);
    w_wr_grant = w_wr_elig && (!w_rd_elig || !last_wr_q);
    w_rd_grant = w_rd_elig && !w_wr_grant;
  end

  assign wr_ready_o        = w_wr_grant;
  assign rd_ready_o        = w_rd_grant;
  assign core_write_fifo_o = core_write_fifo_q;
  assign core_read_fifo_o  = core_read_fifo_q;
  assign core_fifo_in_o    = core_fifo_in_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_data_o       = resp_data_q;
  assign resp_empty_o      = resp_empty_q;
  assign resp_err_o        = resp_err_q;

  // Scheduler FSM with registered strobes, response and per-core gap counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      last_wr_q         <= 1'b0;
      sel_q             <= '0;
      core_write_fifo_q <= '0;
      core_read_fifo_q  <= '0;
      core_fifo_in_q    <= 8'h00;
      resp_valid_q      <= 1'b0;
      resp_data_q       <= 8'h00;
      resp_empty_q      <= 1'b0;
      resp_err_q        <= 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
        gap_q[k] <= 4'd0;
      end
    end else begin
      core_write_fifo_q <= '0;
      core_read_fifo_q  <= '0;
      resp_valid_q      <= 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
        if (gap_q[k] != 4'd0) begin
          gap_q[k] <= gap_q[k] - 4'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (w_wr_grant) begin
            last_wr_q <= 1'b1;
            if (!w_wr_inv) begin
              state_q           <= S_WSTB;
              core_write_fifo_q <= w_wr_onehot;
              core_fifo_in_q    <= wr_data_i;
              // Counter holds GAP during the strobe cycle itself.
              for (int k = 0; k < N_CORES; k++) begin
                if (w_wr_onehot[k]) begin
                  gap_q[k] <= C_GAP;
                end
              end
            end
          end else if (w_rd_grant) begin
            last_wr_q <= 1'b0;
            if (w_rd_inv || w_rd_empty) begin
              state_q      <= S_RCAP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= 8'h00;
              resp_empty_q <= !w_rd_inv;
              resp_err_q   <= w_rd_inv;
            end else begin
              state_q          <= S_RSTB;
              core_read_fifo_q <= w_rd_onehot;
              sel_q            <= rd_core_i;
              for (int k = 0; k < N_CORES; k++) begin
                if (w_rd_onehot[k]) begin
                  gap_q[k] <= C_GAP;
                end
              end
            end
          end
        end
        S_WSTB:  state_q <= S_IDLE;
        S_RSTB:  state_q <= S_RWAIT;
        S_RWAIT: begin
          // fifo_out has settled after the pop strobe; capture it now.
          state_q      <= S_RCAP;
          resp_valid_q <= 1'b1;
          resp_data_q  <= w_cap_data;
          resp_empty_q <= 1'b0;
          resp_err_q   <= 1'b0;
        end
        S_RCAP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
